muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers, issued from the execute stage once the instruction decoder classifies MULT/MULTU/DIV/DIVU/MTHI/MTLO. It is parametrised in operand width and multiplier latency, and runs a valid/ready issue handshake. A busy flag stalls the pipeline, and a flush input aborts in-flight work. MFHI/MFLO read the `hi`/`lo` outputs directly.

---
 rtl/muldiv_unit_pkg.sv | 46 ++++
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit_div_iter.sv | 61 ++++++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the multiply/divide unit: operation and FSM state
// encodings, plus the instruction decode used by both control and this unit.
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } muldiv_state_t;

   localparam logic [5:0] OPC_SPECIAL = 6'h00;
   localparam logic [5:0] FN_MTHI     = 6'h11;
   localparam logic [5:0] FN_MTLO     = 6'h13;
   localparam logic [5:0] FN_MULT     = 6'h18;
   localparam logic [5:0] FN_MULTU    = 6'h19;
   localparam logic [5:0] FN_DIV      = 6'h1a;
   localparam logic [5:0] FN_DIVU     = 6'h1b;

   // Map a MIPS (opcode, funct) pair onto the unit operation; anything else is NONE.
   function automatic muldiv_op_t decode_muldiv(input logic [5:0] opcode,
                                                input logic [5:0] funct);
      decode_muldiv = OP_NONE;
      if (opcode == OPC_SPECIAL) begin
         case (funct)
            FN_MULT:  decode_muldiv = OP_MULT;
            FN_MULTU: decode_muldiv = OP_MULTU;
            FN_DIV:   decode_muldiv = OP_DIV;
            FN_DIVU:  decode_muldiv = OP_DIVU;
            FN_MTHI:  decode_muldiv = OP_MTHI;
            FN_MTLO:  decode_muldiv = OP_MTLO;
            default:  decode_muldiv = OP_NONE;
         endcase
      end
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the execute stage (master) and the unit (slave).
interface muldiv_unit_if
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   muldiv_op_t       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output req_valid, req_op, req_a, req_b, flush,
      input  req_ready, busy, done, hi, lo
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, flush,
      output req_ready, busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle. The final
// iteration's result is presented combinationally while fin is high so the
// parent can commit it on the same edge that would have stored it.
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             fin,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH:0]   partial;
   logic             take;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      partial = {rem_q, quo_q[WIDTH-1]};
      take    = (partial >= {1'b0, dvs_q});
      rem_nxt = take ? (partial[WIDTH-1:0] - dvs_q) : partial[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], take};
   end

   // Shift registers and iteration counter; abort parks the counter at zero.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt   <= '0;
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (abort) begin
         cnt <= '0;
      end else if (start) begin
         cnt   <= CW'(WIDTH);
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
      end else if (cnt != '0) begin
         cnt   <= cnt - CW'(1);
         rem_q <= rem_nxt;
         quo_q <= quo_nxt;
      end
   end

   assign fin = (cnt == CW'(1));
   assign quo = quo_nxt;
   assign rem = rem_nxt;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | ready for an op; MTHI/MTLO complete here in one edge
//   ST_MUL  | product travelling down the multiplier register chain
//   ST_DIV  | div_iter producing one quotient bit per cycle
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 2
) (
   input logic          clk,
   input logic          resetn,
   muldiv_unit_if.slave bus
);
   localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   muldiv_state_t    state;
   logic [MCW-1:0]   mul_cnt;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             done_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             div_signed;

   logic [2*WIDTH-1:0] prod_pipe [MUL_LAT];

   logic               accept;
   logic               op_signed;
   logic               is_mul;
   logic               is_div;
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               div_fin;
   logic [WIDTH-1:0]   div_quo;
   logic [WIDTH-1:0]   div_rem;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Accept decode and operand preparation for both datapaths.
   always_comb begin
      accept    = bus.req_valid && (state == ST_IDLE) && !bus.flush && (bus.req_op != OP_NONE);
      op_signed = (bus.req_op == OP_MULT) || (bus.req_op == OP_DIV);
      is_mul    = (bus.req_op == OP_MULT) || (bus.req_op == OP_MULTU);
      is_div    = (bus.req_op == OP_DIV)  || (bus.req_op == OP_DIVU);
      ext_a     = op_signed ? {{WIDTH{bus.req_a[WIDTH-1]}}, bus.req_a} : {{WIDTH{1'b0}}, bus.req_a};
      ext_b     = op_signed ? {{WIDTH{bus.req_b[WIDTH-1]}}, bus.req_b} : {{WIDTH{1'b0}}, bus.req_b};
      product   = ext_a * ext_b;
      mag_a     = (op_signed && bus.req_a[WIDTH-1]) ? -bus.req_a : bus.req_a;
      mag_b     = (op_signed && bus.req_b[WIDTH-1]) ? -bus.req_b : bus.req_b;
   end

   // Multiplier chain: product captured at accept, then shifted toward the last stage.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < MUL_LAT; i++) prod_pipe[i] <= '0;
      end else begin
         if (accept && is_mul) prod_pipe[0] <= product;
         for (int i = 1; i < MUL_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];
      end
   end

   div_iter #(.WIDTH(WIDTH)) u_div_iter (
      .clk      (clk),
      .resetn   (resetn),
      .start    (accept && is_div),
      .abort    (bus.flush),
      .dividend (mag_a),
      .divisor  (mag_b),
      .fin      (div_fin),
      .quo      (div_quo),
      .rem      (div_rem)
   );

   // Sign fix-up of the magnitude result; a zero divisor yields all-ones / dividend.
   always_comb begin
      quo_fix = div_quo;
      rem_fix = div_rem;
      if (b_q == '0) begin
         quo_fix = '1;
         rem_fix = a_q;
      end else if (div_signed) begin
         if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) quo_fix = -div_quo;
         if (a_q[WIDTH-1])                rem_fix = -div_rem;
      end
   end

   // Control FSM with HI/LO commit and the done pulse.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         mul_cnt    <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         div_signed <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  case (bus.req_op)
                     OP_MTHI: begin
                        hi_q   <= bus.req_a;
                        done_q <= 1'b1;
                     end
                     OP_MTLO: begin
                        lo_q   <= bus.req_a;
                        done_q <= 1'b1;
                     end
                     OP_MULT, OP_MULTU: begin
                        state   <= ST_MUL;
                        mul_cnt <= MCW'(MUL_LAT - 1);
                     end
                     OP_DIV, OP_DIVU: begin
                        state      <= ST_DIV;
                        a_q        <= bus.req_a;
                        b_q        <= bus.req_b;
                        div_signed <= op_signed;
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               if (bus.flush) begin
                  state <= ST_IDLE;
               end else if (mul_cnt == '0) begin
                  hi_q   <= prod_pipe[MUL_LAT-1][2*WIDTH-1:WIDTH];
                  lo_q   <= prod_pipe[MUL_LAT-1][WIDTH-1:0];
                  done_q <= 1'b1;
                  state  <= ST_IDLE;
               end else begin
                  mul_cnt <= mul_cnt - MCW'(1);
               end
            end
            ST_DIV: begin
               if (bus.flush) begin
                  state <= ST_IDLE;
               end else if (div_fin) begin
                  hi_q   <= rem_fix;
                  lo_q   <= quo_fix;
                  done_q <= 1'b1;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready = (state == ST_IDLE);
   assign bus.busy      = (state != ST_IDLE);
   assign bus.done      = done_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases with literal expectations plus a
// random run, all checked every cycle against an op-level reference model.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int W       = 32;
   localparam int MUL_LAT = 2;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   always #5 clk = ~clk;

   muldiv_unit_if #(.WIDTH(W)) bus ();

   muldiv_unit #(.WIDTH(W), .MUL_LAT(MUL_LAT)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0] exp_hi, exp_lo;
   logic         exp_done, exp_busy, exp_ready;
   bit           pend;
   int           pend_due;
   logic [W-1:0] pend_hi, pend_lo;
   int           cyc = 0;
   bit           chk_en = 1'b0;

   task automatic model_reset();
      exp_hi    = '0;
      exp_lo    = '0;
      exp_done  = 1'b0;
      exp_busy  = 1'b0;
      exp_ready = 1'b1;
      pend      = 1'b0;
   endtask

   // Architectural result of an op from plain integer arithmetic.
   task automatic compute(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] rh, output logic [W-1:0] rl);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, p;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      rh = '0;
      rl = '0;
      case (op)
         OP_MULT:  begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
         OP_MULTU: begin p = ua * ub; rh = p[63:32]; rl = p[31:0]; end
         OP_DIV: begin
            if (b == '0) begin rl = '1; rh = a; end
            else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
         end
         OP_DIVU: begin
            if (b == '0) begin rl = '1; rh = a; end
            else begin rl = a / b; rh = a % b; end
         end
         default: ;
      endcase
   endtask

   // Advance the model by one rising edge using the inputs that edge sees.
   task automatic model_edge();
      logic [W-1:0] rh, rl;
      cyc++;
      if (!resetn) return;
      exp_done = 1'b0;
      if (pend) begin
         if (bus.flush) pend = 1'b0;
         else if (cyc == pend_due) begin
            exp_hi   = pend_hi;
            exp_lo   = pend_lo;
            exp_done = 1'b1;
            pend     = 1'b0;
         end
      end else if (bus.req_valid && !bus.flush && bus.req_op != OP_NONE) begin
         case (bus.req_op)
            OP_MTHI: begin exp_hi = bus.req_a; exp_done = 1'b1; end
            OP_MTLO: begin exp_lo = bus.req_a; exp_done = 1'b1; end
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
               compute(bus.req_op, bus.req_a, bus.req_b, rh, rl);
               pend_hi  = rh;
               pend_lo  = rl;
               pend     = 1'b1;
               pend_due = cyc + (((bus.req_op == OP_MULT) || (bus.req_op == OP_MULTU)) ? MUL_LAT : W);
            end
            default: ;
         endcase
      end
      exp_busy  = pend;
      exp_ready = !pend;
   endtask

   // Per-cycle comparison of every output against the model, mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         vectors++;
         if (bus.busy !== exp_busy) begin
            miscompares++;
            $display("FAIL cyc %0d busy: got %b want %b", cyc, bus.busy, exp_busy);
         end
         if (bus.req_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL cyc %0d req_ready: got %b want %b", cyc, bus.req_ready, exp_ready);
         end
         if (bus.done !== exp_done) begin
            miscompares++;
            $display("FAIL cyc %0d done: got %b want %b", cyc, bus.done, exp_done);
         end
         if (bus.hi !== exp_hi) begin
            miscompares++;
            $display("FAIL cyc %0d hi: got %h want %h", cyc, bus.hi, exp_hi);
         end
         if (bus.lo !== exp_lo) begin
            miscompares++;
            $display("FAIL cyc %0d lo: got %h want %h", cyc, bus.lo, exp_lo);
         end
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input muldiv_op_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic f);
      bus.req_valid = v;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.flush     = f;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic issue(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
      drive(1'b1, op, a, b, 1'b0);
      step();
      drive(1'b0, OP_NONE, '0, '0, 1'b0);
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      while (bus.done !== 1'b1 && n < max) begin
         step();
         n++;
      end
      if (bus.done !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_done: no done within %0d cycles", max);
      end
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int n;
      int dones;
      drive(1'b0, OP_NONE, '0, '0, 1'b0);
      model_reset();
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      check("decode_mult", W'(decode_muldiv(6'h00, 6'h18)), W'(OP_MULT));
      check("decode_mtlo", W'(decode_muldiv(6'h00, 6'h13)), W'(OP_MTLO));
      check("decode_other", W'(decode_muldiv(6'h08, 6'h18)), W'(OP_NONE));

      check("rst_hi", bus.hi, 32'h0);
      check("rst_lo", bus.lo, 32'h0);
      check("rst_busy", W'(bus.busy), 32'd0);
      check("rst_ready", W'(bus.req_ready), 32'd1);
      check("rst_done", W'(bus.done), 32'd0);

      issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
      check("mult_busy", W'(bus.busy), 32'd1);
      wait_done(10, n);
      check("mult_latency", W'(n), 32'd2);
      check("mult_hi", bus.hi, 32'hFFFF_FFFF);
      check("mult_lo", bus.lo, 32'hFFFF_FFF1);
      check("mult_model_lo", exp_lo, 32'hFFFF_FFF1);

      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(10, n);
      check("multu_latency", W'(n), 32'd2);
      check("multu_hi", bus.hi, 32'hFFFF_FFFE);
      check("multu_lo", bus.lo, 32'h0000_0001);
      check("done_cycle_ready", W'(bus.req_ready), 32'd1);
      issue(OP_MTLO, 32'h0000_1234, '0);
      check("mtlo_lo", bus.lo, 32'h0000_1234);
      check("mtlo_hi_kept", bus.hi, 32'hFFFF_FFFE);
      check("mtlo_done", W'(bus.done), 32'd1);

      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      check("div_busy", W'(bus.busy), 32'd1);
      wait_done(40, n);
      check("div_latency", W'(n), 32'd32);
      check("div_lo", bus.lo, 32'hFFFF_FFFD);
      check("div_hi", bus.hi, 32'hFFFF_FFFF);
      check("div_model_hi", exp_hi, 32'hFFFF_FFFF);

      issue(OP_DIVU, 32'd7, 32'd2);
      wait_done(40, n);
      check("divu_lo", bus.lo, 32'd3);
      check("divu_hi", bus.hi, 32'd1);

      issue(OP_DIVU, 32'd7, 32'd0);
      wait_done(40, n);
      check("div0_latency", W'(n), 32'd32);
      check("div0_lo", bus.lo, 32'hFFFF_FFFF);
      check("div0_hi", bus.hi, 32'd7);

      issue(OP_MTHI, 32'hA, '0);
      issue(OP_MTLO, 32'hB, '0);
      issue(OP_DIV, 32'd100, 32'd3);
      repeat (9) step();
      drive(1'b1, OP_MTHI, 32'h55, '0, 1'b1);
      step();
      drive(1'b0, OP_NONE, '0, '0, 1'b0);
      check("flush_busy", W'(bus.busy), 32'd0);
      check("flush_ready", W'(bus.req_ready), 32'd1);
      check("flush_done", W'(bus.done), 32'd0);
      check("flush_hi", bus.hi, 32'hA);
      check("flush_lo", bus.lo, 32'hB);
      drive(1'b1, OP_MTHI, 32'h77, '0, 1'b1);
      step();
      drive(1'b0, OP_NONE, '0, '0, 1'b0);
      check("flush_req_hi", bus.hi, 32'hA);
      dones = 0;
      repeat (40) begin
         step();
         if (bus.done === 1'b1) dones++;
      end
      check("flush_no_done", W'(dones), 32'd0);

      issue(OP_MULT, 32'd3, 32'd4);
      step();
      drive(1'b0, OP_NONE, '0, '0, 1'b1);
      step();
      drive(1'b0, OP_NONE, '0, '0, 1'b0);
      check("flush_at_fin_done", W'(bus.done), 32'd0);
      check("flush_at_fin_lo", bus.lo, 32'hB);

      issue(OP_MULT, 32'd6, 32'd7);
      step();
      resetn = 1'b0;
      #1;
      model_reset();
      check("rst_mid_hi", bus.hi, 32'h0);
      check("rst_mid_lo", bus.lo, 32'h0);
      check("rst_mid_busy", W'(bus.busy), 32'd0);
      repeat (2) step();
      @(negedge clk);
      #1;
      resetn = 1'b1;
      dones = 0;
      repeat (4) begin
         step();
         if (bus.done === 1'b1) dones++;
      end
      check("rst_mid_no_done", W'(dones), 32'd0);

      repeat (3000) begin
         drive($urandom_range(0, 3) != 0, muldiv_op_t'($urandom_range(0, 6)),
               rnd_operand(), rnd_operand(), $urandom_range(0, 24) == 0);
         step();
      end
      drive(1'b0, OP_NONE, '0, '0, 1'b0);
      repeat (40) step();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
